// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: CPU-side MMIO decoder with per-region wait states (RAM/ROM/GFX/KBD).
// Optional: define MMIO_BUS_ERR_EN to flag unmapped accesses and ROM/KBD writes on cpu_err.
module mmio_bus_ctrl #(
    parameter int          DATA_W    = 16,
    parameter logic [15:0] RAM_LIMIT = 16'h8000,
    parameter logic [15:0] GFX_BASE  = 16'hF000,
    parameter logic [15:0] GFX_LIMIT = 16'hFA00,
    parameter logic [15:0] ROM_BASE  = 16'hFF00,
    parameter logic [15:0] KBD_ADDR  = 16'hFE00,
    parameter int          RAM_WAIT  = 1,
    parameter int          ROM_WAIT  = 0,
    parameter int          GFX_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic [15:0]       ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_oe,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic [13:0]       gfx_addr,
    output logic [DATA_W-1:0] gfx_wdata,
    output logic              gfx_we,
    input  logic [DATA_W-1:0] kbd_data,
    output logic              kbd_ack
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [2:0] {RG_RAM, RG_ROM, RG_GFX, RG_KBD, RG_NONE} region_t;
    state_t            state;
    region_t           region, dec;
    logic              we;
    logic [7:0]        cnt, dec_wait;
    logic [DATA_W-1:0] rd;
    logic              err;
    always_comb begin
        dec = cpu_addr < RAM_LIMIT ? RG_RAM :
              cpu_addr >= ROM_BASE ? RG_ROM :
              (cpu_addr >= GFX_BASE && cpu_addr < GFX_LIMIT) ? RG_GFX :
              cpu_addr == KBD_ADDR ? RG_KBD : RG_NONE;
        dec_wait = dec == RG_RAM ? 8'(RAM_WAIT) :
                   dec == RG_ROM ? 8'(ROM_WAIT) :
                   dec == RG_GFX ? 8'(GFX_WAIT) : 8'd0;
        rd = region == RG_RAM ? ram_rdata :
             region == RG_ROM ? rom_rdata :
             region == RG_KBD ? kbd_data : '0;
        err = region == RG_NONE || (we && (region == RG_ROM || region == RG_KBD));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            region    <= RG_NONE;
            we        <= 1'b0;
            cnt       <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            rom_addr  <= '0;
            gfx_addr  <= '0;
            gfx_wdata <= '0;
            gfx_we    <= 1'b0;
            kbd_ack   <= 1'b0;
`ifdef MMIO_BUS_ERR_EN
            cpu_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (cpu_req) begin
                    state     <= ACCESS;
                    region    <= dec;
                    we        <= cpu_we;
                    cnt       <= dec_wait;
                    ram_addr  <= {1'b0, cpu_addr[15:1]};
                    rom_addr  <= {8'h00, cpu_addr[7:0]};
                    gfx_addr  <= 14'(cpu_addr - GFX_BASE);
                    ram_wdata <= cpu_wdata;
                    gfx_wdata <= cpu_wdata;
                    ram_oe    <= dec == RG_RAM && !cpu_we;
                    ram_we    <= dec == RG_RAM && cpu_we;
                    gfx_we    <= dec == RG_GFX && cpu_we;
                end
                ACCESS: if (cnt == 8'd0) begin
                    state     <= DONE;
                    ram_oe    <= 1'b0;
                    ram_we    <= 1'b0;
                    gfx_we    <= 1'b0;
                    cpu_ready <= 1'b1;
                    kbd_ack   <= region == RG_KBD && !we;
                    if (!we) cpu_rdata <= rd;
`ifdef MMIO_BUS_ERR_EN
                    cpu_err   <= err;
`endif
                end else begin
                    cnt <= cnt - 8'd1;
                end
                default: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b0;
                    kbd_ack   <= 1'b0;
`ifdef MMIO_BUS_ERR_EN
                    cpu_err   <= 1'b0;
`endif
                end
            endcase
        end
    end
`ifndef MMIO_BUS_ERR_EN
    assign cpu_err = 1'b0;
    logic unused_err;
    assign unused_err = err;
`endif
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: directed-vector bench for mmio_bus_ctrl.
module tb_mmio_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst, cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready, cpu_err;
    logic [15:0] ram_addr, ram_wdata, ram_rdata, rom_addr, rom_rdata, gfx_wdata, kbd_data;
    logic        ram_we, ram_oe, gfx_we, kbd_ack;
    logic [13:0] gfx_addr;
    int          n_chk = 0, n_fail = 0;
    int          rdy_cyc, rdy_n, oe_n, rwe_n, gwe_n, ack_n, both_n;
    logic        err_rdy;
    logic        err_exp;

    always #5 clk = ~clk;

    mmio_bus_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_rdata(ram_rdata), .rom_addr(rom_addr), .rom_rdata(rom_rdata), .gfx_addr(gfx_addr),
        .gfx_wdata(gfx_wdata), .gfx_we(gfx_we), .kbd_data(kbd_data), .kbd_ack(kbd_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Request sampled at edge 0; cycle k is the interval after edge k-1.
    task automatic run(input logic [15:0] a, input logic w, input logic [15:0] d);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = d;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        rdy_cyc = 0; rdy_n = 0; oe_n = 0; rwe_n = 0; gwe_n = 0; ack_n = 0; both_n = 0; err_rdy = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            oe_n  += int'(ram_oe);
            rwe_n += int'(ram_we);
            gwe_n += int'(gfx_we);
            ack_n += int'(kbd_ack);
            both_n += int'(kbd_ack && cpu_ready);
            if (cpu_ready) begin
                rdy_n++;
                if (rdy_cyc == 0) begin rdy_cyc = c; err_rdy = cpu_err; end
            end
            @(negedge clk);
        end
        if (rdy_n == 0) $display("FAIL timeout %h: no cpu_ready within budget got 0 expected 1", a);
    endtask

    initial begin
`ifdef MMIO_BUS_ERR_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ram_rdata = 16'hBEEF; rom_rdata = 16'h1234; kbd_data = 16'h0041;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cpu_ready, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_strobes", {ram_oe, ram_we, gfx_we, kbd_ack, cpu_err}, 0);
        check("rst_addrs", {ram_addr, rom_addr, gfx_addr}, 0);
        rst = 1'b0;

        run(16'h0124, 1'b0, 16'h0000);
        check("ram_addr", ram_addr, 16'h0092);
        check("ram_oe_cycles", oe_n, 2);
        check("ram_we_cycles", rwe_n, 0);
        check("ram_ready_cyc", rdy_cyc, 3);
        check("ram_ready_cnt", rdy_n, 1);
        check("ram_rdata", cpu_rdata, 16'hBEEF);
        check("ram_err", err_rdy, 0);

        run(16'hF010, 1'b1, 16'h00AA);
        check("gfx_addr", gfx_addr, 14'h0010);
        check("gfx_wdata", gfx_wdata, 16'h00AA);
        check("gfx_we_cycles", gwe_n, 3);
        check("gfx_other_strobes", oe_n + rwe_n, 0);
        check("gfx_ready_cyc", rdy_cyc, 4);

        run(16'hFF05, 1'b0, 16'h0000);
        check("rom_addr", rom_addr, 16'h0005);
        check("rom_ready_cyc", rdy_cyc, 2);
        check("rom_rdata", cpu_rdata, 16'h1234);

        run(16'hFE00, 1'b0, 16'h0000);
        check("kbd_rdata", cpu_rdata, 16'h0041);
        check("kbd_ack_cnt", ack_n, 1);
        check("kbd_ready_cnt", rdy_n, 1);
        check("kbd_ack_with_ready", both_n, 1);
        check("kbd_ready_cyc", rdy_cyc, 2);

        run(16'hFB00, 1'b0, 16'h0000);
        check("unmap_rdata", cpu_rdata, 16'h0000);
        check("unmap_ready_cyc", rdy_cyc, 2);
        check("unmap_err", err_rdy, err_exp);

        run(16'hFF10, 1'b1, 16'h5555);
        check("romwr_strobes", oe_n + rwe_n + gwe_n + ack_n, 0);
        check("romwr_ready_cyc", rdy_cyc, 2);
        check("romwr_err", err_rdy, err_exp);

        // Reset during the second ACCESS cycle of a GFX write.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hF020; cpu_wdata = 16'h0077;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        check("abort_gfx_we_c1", gfx_we, 1);
        @(negedge clk);
        check("abort_gfx_we_c2", gfx_we, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_gfx_we_off", gfx_we, 0);
        rdy_n = 0;
        for (int c = 0; c < 6; c++) begin
            rdy_n += int'(cpu_ready);
            @(negedge clk);
        end
        check("abort_no_ready", rdy_n, 0);

        ram_rdata = 16'hCAFE;
        run(16'h0200, 1'b0, 16'h0000);
        check("post_ram_addr", ram_addr, 16'h0100);
        check("post_ready_cyc", rdy_cyc, 3);
        check("post_rdata", cpu_rdata, 16'hCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
